// File: rtl/pmp_pkg.sv
// Shared types and constants for the sequential PMP checker.
package pmp_pkg;

    // Physical-address width of this configuration.
    localparam int unsigned PA_BITS = 34;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StDone
    } pmp_state_e;

    typedef enum logic [1:0] {
        AccNone  = 2'b00,
        AccRead  = 2'b01,
        AccWrite = 2'b10,
        AccExec  = 2'b11
    } pmp_acc_e;

    typedef enum logic [1:0] {
        AddrOff   = 2'b00,
        AddrTor   = 2'b01,
        AddrNa4   = 2'b10,
        AddrNapot = 2'b11
    } pmp_amode_e;

    // True when the R/W/X bit selected by the access type is set in the cfg byte.
    function automatic logic pmp_perm_ok(input logic [7:0] cfg, input logic [1:0] acc);
        case (acc)
            AccRead:  return cfg[0];
            AccWrite: return cfg[1];
            AccExec:  return cfg[2];
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/pmpadrdec.sv
// Single-entry PMP address decoder (TOR / NA4 / NAPOT).
module pmpadrdec
    import pmp_pkg::*;
(
    input  logic [PA_BITS-1:0] addr_i,
    input  logic [PA_BITS-3:0] pmp_adr_i,
    input  logic [1:0]         amode_i,
    input  logic               prev_ge_i,
    output logic               match_o,
    output logic               ge_o
);

    logic [PA_BITS-3:0] word_addr;
    logic [PA_BITS-3:0] adr_plus1;
    logic [PA_BITS-3:0] napot_mask;

    assign word_addr = addr_i[PA_BITS-1:2];
    assign ge_o      = addr_i >= {pmp_adr_i, 2'b00};
    // adr ^ (adr+1) marks the trailing-ones run plus one bit: those bits are "don't care".
    assign adr_plus1  = pmp_adr_i + {{(PA_BITS-3){1'b0}}, 1'b1};
    assign napot_mask = ~(pmp_adr_i ^ adr_plus1);

    // Region match for the selected addressing mode.
    always_comb begin
        match_o = 1'b0;
        case (amode_i)
            AddrTor:   match_o = prev_ge_i & ~ge_o;
            AddrNa4:   match_o = (word_addr == pmp_adr_i);
            AddrNapot: match_o = ((word_addr ^ pmp_adr_i) & napot_mask) == '0;
            default:   match_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/pmp_seq_checker.sv
// Sequential PMP checker: scans one entry per cycle through a shared decoder.
module pmp_seq_checker
    import pmp_pkg::*;
#(
    parameter int unsigned PMP_ENTRIES = 16
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   ReqValid,
    output logic                                   ReqReady,
    input  logic [PA_BITS-1:0]                     PhysicalAddress,
    input  logic [1:0]                             Size,
    input  logic [1:0]                             AccessType,
    input  logic [1:0]                             PrivMode,
    input  logic [PMP_ENTRIES-1:0][7:0]            PMPCfg,
    input  logic [PMP_ENTRIES-1:0][PA_BITS-3:0]    PMPAdr,
    input  logic                                   PMPCfgWrite,
    output logic                                   RespValid,
    input  logic                                   RespReady,
    output logic                                   AccessFault,
    output logic                                   MatchValid,
    output logic [5:0]                             MatchIdx
);

    localparam int unsigned IdxW    = (PMP_ENTRIES > 1) ? $clog2(PMP_ENTRIES) : 1;
    localparam logic [5:0]  LastIdx = 6'(PMP_ENTRIES - 1);

    pmp_state_e         state_q, state_d;
    logic [5:0]         idx_q, idx_d;
    logic               tor_q, tor_d;
    logic [PA_BITS-1:0] addr_q, addr_d;
    logic [1:0]         size_q, size_d;
    logic [1:0]         acc_q, acc_d;
    logic [1:0]         priv_q, priv_d;
    logic               resp_valid_q, resp_valid_d;
    logic               fault_q, fault_d;
    logic               match_valid_q, match_valid_d;
    logic [5:0]         match_idx_q, match_idx_d;

    logic [IdxW-1:0]    sel;
    logic [7:0]         cfg_sel;
    logic [PA_BITS-3:0] adr_sel;
    logic               dec_match;
    logic               dec_ge;
    logic               entry_fault;
    logic               unused_size;

    // Size is carried with the request but does not affect the match.
    assign unused_size = ^size_q;

    // Live cfg/address of the entry under scan.
    assign sel     = idx_q[IdxW-1:0];
    assign cfg_sel = PMPCfg[sel];
    assign adr_sel = PMPAdr[sel];

    pmpadrdec u_adrdec (
        .addr_i    (addr_q),
        .pmp_adr_i (adr_sel),
        .amode_i   (cfg_sel[4:3]),
        .prev_ge_i (tor_q),
        .match_o   (dec_match),
        .ge_o      (dec_ge)
    );

    // M-mode passes unlocked entries; otherwise the selected permission bit decides.
    assign entry_fault = ~((priv_q == 2'b11) && !cfg_sel[7]) && !pmp_perm_ok(cfg_sel, acc_q);

    // Next-state and result computation for the scan FSM.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        tor_d         = tor_q;
        addr_d        = addr_q;
        size_d        = size_q;
        acc_d         = acc_q;
        priv_d        = priv_q;
        resp_valid_d  = resp_valid_q;
        fault_d       = fault_q;
        match_valid_d = match_valid_q;
        match_idx_d   = match_idx_q;
        unique case (state_q)
            StIdle: begin
                if (ReqValid) begin
                    state_d = StScan;
                    idx_d   = '0;
                    tor_d   = 1'b1;
                    addr_d  = PhysicalAddress;
                    size_d  = Size;
                    acc_d   = AccessType;
                    priv_d  = PrivMode;
                end
            end
            StScan: begin
                if (PMPCfgWrite) begin
                    // CSRs changed under us: results so far are stale, rescan.
                    idx_d = '0;
                    tor_d = 1'b1;
                end else begin
                    tor_d = dec_ge;
                    if (dec_match) begin
                        state_d       = StDone;
                        resp_valid_d  = 1'b1;
                        match_valid_d = 1'b1;
                        match_idx_d   = idx_q;
                        fault_d       = entry_fault;
                    end else if (idx_q == LastIdx) begin
                        state_d       = StDone;
                        resp_valid_d  = 1'b1;
                        match_valid_d = 1'b0;
                        match_idx_d   = '0;
                        fault_d       = (priv_q != 2'b11);
                    end else begin
                        idx_d = idx_q + 6'd1;
                    end
                end
            end
            StDone: begin
                if (RespReady) begin
                    state_d      = StIdle;
                    resp_valid_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, scan position, latched request and registered results.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            idx_q         <= '0;
            tor_q         <= 1'b1;
            addr_q        <= '0;
            size_q        <= '0;
            acc_q         <= '0;
            priv_q        <= '0;
            resp_valid_q  <= 1'b0;
            fault_q       <= 1'b0;
            match_valid_q <= 1'b0;
            match_idx_q   <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            tor_q         <= tor_d;
            addr_q        <= addr_d;
            size_q        <= size_d;
            acc_q         <= acc_d;
            priv_q        <= priv_d;
            resp_valid_q  <= resp_valid_d;
            fault_q       <= fault_d;
            match_valid_q <= match_valid_d;
            match_idx_q   <= match_idx_d;
        end
    end

    assign ReqReady    = (state_q == StIdle);
    assign RespValid   = resp_valid_q;
    assign AccessFault = fault_q;
    assign MatchValid  = match_valid_q;
    assign MatchIdx    = match_idx_q;

endmodule

// File: tb/tb_pmp_seq_checker.sv
// Self-checking bench for pmp_seq_checker with a response scoreboard.
module tb_pmp_seq_checker;
    import pmp_pkg::*;

    localparam int N = 16;

    logic                         clk = 1'b0;
    logic                         reset = 1'b1;
    logic                         ReqValid = 1'b0;
    logic                         ReqReady;
    logic [PA_BITS-1:0]           PhysicalAddress = '0;
    logic [1:0]                   Size = 2'b10;
    logic [1:0]                   AccessType = 2'b01;
    logic [1:0]                   PrivMode = 2'b00;
    logic [N-1:0][7:0]            cfg;
    logic [N-1:0][PA_BITS-3:0]    adr;
    logic                         PMPCfgWrite = 1'b0;
    logic                         RespValid;
    logic                         RespReady = 1'b1;
    logic                         AccessFault;
    logic                         MatchValid;
    logic [5:0]                   MatchIdx;

    pmp_seq_checker #(.PMP_ENTRIES(N)) dut (
        .clk             (clk),
        .reset           (reset),
        .ReqValid        (ReqValid),
        .ReqReady        (ReqReady),
        .PhysicalAddress (PhysicalAddress),
        .Size            (Size),
        .AccessType      (AccessType),
        .PrivMode        (PrivMode),
        .PMPCfg          (cfg),
        .PMPAdr          (adr),
        .PMPCfgWrite     (PMPCfgWrite),
        .RespValid       (RespValid),
        .RespReady       (RespReady),
        .AccessFault     (AccessFault),
        .MatchValid      (MatchValid),
        .MatchIdx        (MatchIdx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic       f;
        logic       mv;
        logic [5:0] mi;
        int         lat;
        int         start;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Pop and compare on each response handshake.
    always @(negedge clk) begin
        if (!reset && RespValid && RespReady) begin
            if (sb.size() == 0) begin
                check_val("spurious_resp", 64'd1, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check_val("fault", 64'(AccessFault), 64'(mon_e.f));
                check_val("match_valid", 64'(MatchValid), 64'(mon_e.mv));
                if (mon_e.mv) check_val("match_idx", 64'(MatchIdx), 64'(mon_e.mi));
                check_val("latency", 64'(cyc - mon_e.start), 64'(mon_e.lat));
            end
        end
    end

    // Drive one request (caller is #1 after a rising edge); optional CSR-write pulse cycle.
    task automatic send(input logic [PA_BITS-1:0] a, input logic [1:0] acc, input logic [1:0] pv,
                        input logic f, input logic mv, input logic [5:0] mi, input int lat,
                        input int wr_cyc);
        int n = 0;
        while (!ReqReady && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check_val("req_ready_wait", 64'(ReqReady), 64'd1);
        PhysicalAddress = a;
        AccessType      = acc;
        PrivMode        = pv;
        ReqValid        = 1'b1;
        sb.push_back('{f, mv, mi, lat, cyc});
        @(posedge clk); #1;
        ReqValid = 1'b0;
        if (wr_cyc > 0) begin
            repeat (wr_cyc - 1) @(posedge clk);
            #1;
            PMPCfgWrite = 1'b1;
            @(posedge clk); #1;
            PMPCfgWrite = 1'b0;
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb.size() != 0) begin
            check_val("resp_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    task automatic run_req(input logic [PA_BITS-1:0] a, input logic [1:0] acc,
                           input logic [1:0] pv, input logic f, input logic mv,
                           input logic [5:0] mi, input int lat, input int wr_cyc);
        send(a, acc, pv, f, mv, mi, lat, wr_cyc);
        wait_done();
    endtask

    // Range-based reference: first matching entry, fault and latency.
    function automatic void model(input logic [PA_BITS-1:0] a, input logic [1:0] acc,
                                  input logic [1:0] pv, output logic f, output logic mv,
                                  output logic [5:0] mi, output int lat);
        logic [63:0] aa, lo, hi, sz, base;
        logic [7:0]  c;
        logic        perm;
        int          k, j;
        aa = {30'd0, a};
        mv = 1'b0;
        mi = '0;
        lat = N + 1;
        c = '0;
        for (int i = 0; i < N; i++) begin
            c = cfg[i[3:0]];
            base = {30'd0, adr[i[3:0]], 2'b00};
            lo = 64'd1;
            hi = 64'd0;
            if (c[4:3] == 2'b01) begin
                j = i - 1;
                lo = (i == 0) ? 64'd0 : {30'd0, adr[j[3:0]], 2'b00};
                hi = base;
            end else if (c[4:3] == 2'b10) begin
                lo = base;
                hi = base + 64'd4;
            end else if (c[4:3] == 2'b11) begin
                k = 0;
                while (k < 32 && adr[i[3:0]][k[4:0]]) k++;
                sz = 64'd8 << k;
                lo = base & ~(sz - 64'd1);
                hi = lo + sz;
            end
            if (aa >= lo && aa < hi) begin
                mv  = 1'b1;
                mi  = 6'(i);
                lat = i + 2;
                break;
            end
        end
        if (mv) begin
            perm = (acc == 2'b01) ? c[0] : (acc == 2'b10) ? c[1] : (acc == 2'b11) ? c[2] : 1'b0;
            f = ((pv == 2'b11) && !c[7]) ? 1'b0 : !perm;
        end else begin
            f = (pv != 2'b11);
        end
    endfunction

    task automatic clear_pmp();
        cfg = '0;
        adr = '0;
    endtask

    logic        ef, emv;
    logic [5:0]  emi;
    int          elat;
    logic [PA_BITS-1:0] ra;
    logic [7:0]  cfg_tbl [8] = '{8'h00, 8'h0F, 8'h19, 8'h1F, 8'h15, 8'h98, 8'h8F, 8'h1C};
    logic [1:0]  priv_tbl [3] = '{2'b00, 2'b01, 2'b11};

    initial begin
        clear_pmp();
        #7;
        check_val("rst_req_ready", 64'(ReqReady), 64'd1);
        check_val("rst_resp_valid", 64'(RespValid), 64'd0);
        check_val("rst_fault", 64'(AccessFault), 64'd0);
        check_val("rst_match_valid", 64'(MatchValid), 64'd0);
        check_val("rst_match_idx", 64'(MatchIdx), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // NAPOT entry 0, S-mode read ok / write denied
        cfg[0] = 8'h19; adr[0] = 32'h1FF;
        run_req(34'h100, AccRead,  2'b01, 1'b0, 1'b1, 6'd0, 2, -1);
        run_req(34'h100, AccWrite, 2'b01, 1'b1, 1'b1, 6'd0, 2, -1);

        // TOR on entry 3 with lower bound from entry 2 (off)
        clear_pmp();
        cfg[2] = 8'h00; adr[2] = 32'h400;
        cfg[3] = 8'h0F; adr[3] = 32'h800;
        run_req(34'h1800, AccRead, 2'b00, 1'b0, 1'b1, 6'd3, 5, -1);
        run_req(34'h1000, AccRead, 2'b00, 1'b0, 1'b1, 6'd3, 5, -1);
        run_req(34'h1FFC, AccRead, 2'b00, 1'b0, 1'b1, 6'd3, 5, -1);
        run_req(34'h2000, AccRead, 2'b00, 1'b1, 1'b0, 6'd0, 17, -1);
        run_req(34'h0FFC, AccRead, 2'b00, 1'b1, 1'b0, 6'd0, 17, -1);

        // M-mode: unlocked passes, locked enforces, no match passes
        clear_pmp();
        cfg[0] = 8'h18; adr[0] = 32'h1FF;
        run_req(34'h10, AccRead, 2'b11, 1'b0, 1'b1, 6'd0, 2, -1);
        cfg[0] = 8'h98;
        run_req(34'h10, AccRead, 2'b11, 1'b1, 1'b1, 6'd0, 2, -1);
        clear_pmp();
        run_req(34'h10, AccRead, 2'b11, 1'b0, 1'b0, 6'd0, 17, -1);

        // NA4 on entry 1: exact word only
        cfg[1] = 8'h14; adr[1] = 32'h40;
        run_req(34'h100, AccExec, 2'b01, 1'b0, 1'b1, 6'd1, 3, -1);
        run_req(34'h100, AccRead, 2'b01, 1'b1, 1'b1, 6'd1, 3, -1);
        run_req(34'h104, AccExec, 2'b01, 1'b1, 1'b0, 6'd0, 17, -1);

        // Match at entry 5, then CSR write in cycle 3 forces rescan
        clear_pmp();
        cfg[5] = 8'h1F; adr[5] = 32'h1FF;
        run_req(34'h100, AccRead, 2'b01, 1'b0, 1'b1, 6'd5, 7, -1);
        run_req(34'h100, AccRead, 2'b01, 1'b0, 1'b1, 6'd5, 10, 3);

        // Back-pressure in DONE: hold outputs, ignore ReqValid and CSR writes
        clear_pmp();
        cfg[0] = 8'h19; adr[0] = 32'h1FF;
        RespReady = 1'b0;
        send(34'h100, AccWrite, 2'b01, 1'b1, 1'b1, 6'd0, 7, -1);
        begin
            int n = 0;
            while (!RespValid && n < 50) begin
                @(posedge clk); #1;
                n++;
            end
        end
        check_val("stall_resp_seen", 64'(RespValid), 64'd1);
        ReqValid = 1'b1;
        PhysicalAddress = 34'h3000;
        AccessType = AccRead;
        PMPCfgWrite = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check_val("stall_valid", 64'(RespValid), 64'd1);
            check_val("stall_fault", 64'(AccessFault), 64'd1);
            check_val("stall_match_valid", 64'(MatchValid), 64'd1);
            check_val("stall_match_idx", 64'(MatchIdx), 64'd0);
            check_val("stall_req_ready", 64'(ReqReady), 64'd0);
            @(posedge clk); #1;
        end
        ReqValid = 1'b0;
        PMPCfgWrite = 1'b0;
        RespReady = 1'b1;
        @(posedge clk); #1;
        check_val("post_stall_req_ready", 64'(ReqReady), 64'd1);
        check_val("post_stall_resp_valid", 64'(RespValid), 64'd0);
        check_val("post_stall_sb_empty", 64'(sb.size()), 64'd0);

        // Asynchronous reset in the middle of cycle 3 of a scan
        clear_pmp();
        cfg[5] = 8'h1F; adr[5] = 32'h1FF;
        send(34'h100, AccRead, 2'b01, 1'b0, 1'b1, 6'd5, 7, -1);
        @(posedge clk); #1;
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        check_val("arst_resp_valid", 64'(RespValid), 64'd0);
        check_val("arst_req_ready", 64'(ReqReady), 64'd1);
        check_val("arst_fault", 64'(AccessFault), 64'd0);
        check_val("arst_match_valid", 64'(MatchValid), 64'd0);
        check_val("arst_match_idx", 64'(MatchIdx), 64'd0);
        sb.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        run_req(34'h100, AccRead, 2'b01, 1'b0, 1'b1, 6'd5, 7, -1);

        // Randomised configurations against the range model
        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < N; i++) begin
                cfg[i[3:0]] = cfg_tbl[$urandom_range(0, 7)];
                adr[i[3:0]] = 32'($urandom_range(0, 32'hFFF));
            end
            ra = 34'($urandom_range(0, 32'h3FFF)) & ~34'd3;
            AccessType = 2'($urandom_range(1, 3));
            PrivMode = priv_tbl[$urandom_range(0, 2)];
            model(ra, AccessType, PrivMode, ef, emv, emi, elat);
            run_req(ra, AccessType, PrivMode, ef, emv, emi, elat, -1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (errors=%0d)", n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule
